gmm_vmm_sequencer: RTL and testbench
====================================

# gmm_vmm_sequencer

Job-level sequencer for the GMM serial-parallel complex vector-matrix multiplier. On a `start` pulse it reads the N_VARIABLE mean-difference/covariance-row beats from the operand buffers and drives the multiplier's clock enable. It then captures the N_VARIABLE complex results at the pipeline-latency-adjusted ticks and presents them on a valid/ready output port. Output backpressure stalls the whole datapath through `vmm_ce`, so no result is ever lost or duplicated.

## Interface
- D_WIDTH, 16, operand width; results are 2*D_WIDTH signed.
- N_VARIABLE, 4, beats fed and results produced per job (>=2).
- PIPE_LAT, 4, enabled cycles from an operand beat at the multiplier input to its result at `vmm_y_*`.
- ADDR_W, max(1,$clog2(N_VARIABLE)), derived; not overridden.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  job request; accepted only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- rd_en  out  1  operand buffer read/clock enable; buffer output register holds when low.
- rd_addr  out  ADDR_W  beat index into the s and G-row buffers (1-cycle read latency).
- vmm_ce  out  1  multiplier clock enable.
- vmm_y_r, vmm_y_i  in  2*D_WIDTH signed  multiplier result.
- out_y_r, out_y_i  out  2*D_WIDTH signed  registered result.
- out_idx  out  ADDR_W  result index 0..N_VARIABLE-1.
- out_last  out  1  marks index N_VARIABLE-1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.

## Operation
- States: IDLE, RUN, DRAIN. Tick counter `t` (width holds N_VARIABLE+PIPE_LAT). It advances only on cycles with vmm_ce=1.
- IDLE: vmm_ce=0, rd_en=0. When start=1, clear t=0 and go to RUN. `start` in any other state is ignored and not queued.
- RUN:
  - vmm_ce = !out_valid | out_ready.
  - rd_en = vmm_ce & (t < N_VARIABLE); rd_addr = t[ADDR_W-1:0] while t < N_VARIABLE, else hold the last value.
  - Capture window is t in [1+PIPE_LAT, N_VARIABLE+PIPE_LAT]. On a vmm_ce cycle in the window, register vmm_y_* into out_y_*, set out_valid=1, and set out_idx = t-1-PIPE_LAT.
  - On the capture at t = N_VARIABLE+PIPE_LAT, go to DRAIN.
- DRAIN: vmm_ce=0, rd_en=0. Hold out_* until out_valid & out_ready, then go to IDLE and pulse done.
- out_valid clears on a handshake when no capture occurs in the same cycle. A capture coincident with a handshake overwrites the register and keeps valid=1.
- out_last = out_valid & (out_idx == N_VARIABLE-1).
- Results are passed through unmodified, full 2*D_WIDTH width, no rounding or saturation.

## Timing
- Reset (rst=0 at a rising edge) forces state=IDLE, t=0, busy=0, done=0, rd_en=0, rd_addr=0, vmm_ce=0, out_valid=0, out_idx=0, out_y_r=out_y_i=0. It overrides everything, including mid-job; any partial job is discarded.
- The latencies below assume start is sampled high in cycle 0 with out_ready held at 1:
  - RUN begins cycle 1, with rd_en=1 in cycles 1..N_VARIABLE.
  - out_valid is high in cycles PIPE_LAT+3 .. N_VARIABLE+PIPE_LAT+2.
  - done pulses and busy falls in cycle N_VARIABLE+PIPE_LAT+3.
- Each cycle with out_valid=1 and out_ready=0 in RUN lengthens the job by exactly one cycle. rd_en, t and the multiplier all freeze during that cycle.
- done is registered. The done cycle is IDLE, so a start in that same cycle is accepted, giving back-to-back jobs.
- Outputs are registered, except vmm_ce and rd_en, which depend combinationally on out_ready.

## Test plan
- Reset mid-job: assert rst=0 during RUN at t=3 -> next cycle all outputs at reset values; a start after release yields a complete, correct job.
- Nominal job (N_VARIABLE=4, PIPE_LAT=4, out_ready=1): start in cycle 0 -> rd_addr 0,1,2,3 in cycles 1-4; out_valid in cycles 7-10 with idx 0..3; out_last in cycle 10; done in cycle 11. out_y equals the vmm_y value sampled the cycle before each valid.
- Backpressure: drop out_ready in cycles 7-9 -> vmm_ce=0 and rd_en=0 in those cycles; idx 0 is held stable; all 4 results are delivered in order; done in cycle 14.
- Stall in DRAIN: hold out_ready=0 for 5 cycles while idx 3 is pending -> vmm_ce stays 0, busy stays 1, done appears one cycle after the handshake.
- start while busy: pulse start in cycles 2 and 8 -> ignored; exactly one done; t is unaffected.
- Back-to-back: assert start in the done cycle -> second job's rd_en asserts in the next cycle; second job's timing equals the first, offset by 11 cycles.

Source files
------------

// File: rtl/gmm_vmm_sequencer_if.sv
// Handshake and datapath bundle between the GMM VMM job sequencer, its operand buffers,
// the multiplier and the downstream result consumer.
interface gmm_vmm_sequencer_if #(
  parameter int D_WIDTH    = 16,
  parameter int N_VARIABLE = 4
);
  localparam int ADDR_W = ($clog2(N_VARIABLE) > 1) ? $clog2(N_VARIABLE) : 1;

  logic                        start;
  logic                        busy;
  logic                        done;
  logic                        rd_en;
  logic [ADDR_W-1:0]           rd_addr;
  logic                        vmm_ce;
  logic signed [2*D_WIDTH-1:0] vmm_y_r;
  logic signed [2*D_WIDTH-1:0] vmm_y_i;
  logic signed [2*D_WIDTH-1:0] out_y_r;
  logic signed [2*D_WIDTH-1:0] out_y_i;
  logic [ADDR_W-1:0]           out_idx;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    input  start, vmm_y_r, vmm_y_i, out_ready,
    output busy, done, rd_en, rd_addr, vmm_ce,
           out_y_r, out_y_i, out_idx, out_last, out_valid
  );

  modport slave (
    output start, vmm_y_r, vmm_y_i, out_ready,
    input  busy, done, rd_en, rd_addr, vmm_ce,
           out_y_r, out_y_i, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/gmm_vmm_sequencer.sv
// Job sequencer for the serial-parallel complex VMM: feeds N_VARIABLE operand beats, captures
// N_VARIABLE results PIPE_LAT enabled ticks later; a pending unaccepted result freezes the whole datapath.
module gmm_vmm_sequencer #(
  parameter int D_WIDTH    = 16,
  parameter int N_VARIABLE = 4,
  parameter int PIPE_LAT   = 4
) (
  input logic                 clk,
  input logic                 rst,
  gmm_vmm_sequencer_if.master io
);
  localparam int ADDR_W = ($clog2(N_VARIABLE) > 1) ? $clog2(N_VARIABLE) : 1;
  localparam int T_W    = $clog2(N_VARIABLE + PIPE_LAT + 1);

  localparam logic [T_W-1:0]    T_NV     = T_W'(N_VARIABLE);
  localparam logic [T_W-1:0]    T_FIRST  = T_W'(PIPE_LAT + 1);
  localparam logic [T_W-1:0]    T_LAST   = T_W'(N_VARIABLE + PIPE_LAT);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_VARIABLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [T_W-1:0]              t;
  logic [T_W-1:0]              t_inc;
  logic [ADDR_W-1:0]           rd_addr_q;
  logic signed [2*D_WIDTH-1:0] out_y_r_q, out_y_i_q;
  logic [ADDR_W-1:0]           out_idx_q;
  logic                        out_valid_q;
  logic                        done_q;
  logic                        ce;
  logic                        rd;
  logic                        capture;
  logic                        hs;

  assign t_inc = t + T_W'(1);
  assign hs    = out_valid_q & io.out_ready;

  always_comb begin
    state_nxt = state;
    ce        = 1'b0;
    rd        = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) state_nxt = RUN;
      end
      RUN: begin
        // A held result that nobody takes stops feed, multiplier and tick count together.
        ce      = !out_valid_q | io.out_ready;
        rd      = ce & (t < T_NV);
        capture = ce & (t >= T_FIRST) & (t <= T_LAST);
        if (capture && (t == T_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      t           <= '0;
      rd_addr_q   <= '0;
      out_y_r_q   <= '0;
      out_y_i_q   <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == DRAIN) && hs;

      if (state == IDLE && io.start) begin
        t         <= '0;
        rd_addr_q <= '0;
      end else if (ce) begin
        t <= t_inc;
        // rd_addr tracks t while beats remain, then parks on the last beat.
        if (t_inc < T_NV) rd_addr_q <= ADDR_W'(t_inc);
      end

      if (capture) begin
        out_y_r_q   <= io.vmm_y_r;
        out_y_i_q   <= io.vmm_y_i;
        out_idx_q   <= ADDR_W'(t - T_FIRST);
        out_valid_q <= 1'b1;
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign io.busy      = (state != IDLE);
  assign io.done      = done_q;
  assign io.rd_en     = rd;
  assign io.rd_addr   = rd_addr_q;
  assign io.vmm_ce    = ce;
  assign io.out_y_r   = out_y_r_q;
  assign io.out_y_i   = out_y_i_q;
  assign io.out_idx   = out_idx_q;
  assign io.out_valid = out_valid_q;
  assign io.out_last  = out_valid_q & (out_idx_q == IDX_LAST);
endmodule

// File: tb/tb_gmm_vmm_sequencer.sv
// Directed bench: per-cycle vector tables for whole jobs plus hand-written reset, drain-stall
// and back-to-back sequences, with a behavioural operand buffer and delay-line multiplier.
module tb_gmm_vmm_sequencer;
  localparam int DW = 16;
  localparam int NV = 4;
  localparam int PL = 4;

  logic clk;
  logic rst;

  gmm_vmm_sequencer_if #(.D_WIDTH(DW), .N_VARIABLE(NV)) bus ();

  gmm_vmm_sequencer #(.D_WIDTH(DW), .N_VARIABLE(NV), .PIPE_LAT(PL)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer (1-cycle read, holds when rd_en low) and a PIPE_LAT-stage enabled delay line.
  logic signed [31:0] mem_r [NV];
  logic signed [31:0] mem_i [NV];
  logic signed [31:0] buf_r, buf_i;
  logic signed [31:0] pipe_r [PL];
  logic signed [31:0] pipe_i [PL];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      buf_r <= mem_r[bus.rd_addr];
      buf_i <= mem_i[bus.rd_addr];
    end
    if (bus.vmm_ce) begin
      pipe_r[0] <= buf_r;
      pipe_i[0] <= buf_i;
      for (int k = 1; k < PL; k++) begin
        pipe_r[k] <= pipe_r[k-1];
        pipe_i[k] <= pipe_i[k-1];
      end
    end
  end

  assign bus.vmm_y_r = pipe_r[PL-1];
  assign bus.vmm_y_i = pipe_i[PL-1];

  typedef struct {
    bit st, rdy;
    bit bsy, dn, re;
    int ra;
    bit ce, vl;
    int ix;
    bit ls;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;
  logic [31:0] cur_base;

  function automatic vec_t v(bit st, bit rdy, bit bsy, bit dn, bit re, int ra,
                             bit ce, bit vl, int ix, bit ls);
    vec_t r;
    r.st = st; r.rdy = rdy; r.bsy = bsy; r.dn = dn; r.re = re; r.ra = ra;
    r.ce = ce; r.vl = vl; r.ix = ix; r.ls = ls;
    return r;
  endfunction

  function automatic logic [31:0] dr(int i);
    return cur_base + 32'(i) * 32'h0001_0001;
  endfunction

  function automatic logic [31:0] di(int i);
    return ~dr(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic load(input logic [31:0] base);
    cur_base = base;
    for (int i = 0; i < NV; i++) begin
      mem_r[i] = dr(i);
      mem_i[i] = di(i);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_y(input string name, input int idx);
    chk({name, " y"}, {bus.out_y_r, bus.out_y_i}, {dr(idx), di(idx)});
  endtask

  task automatic run_seg(input int first, input int last, input int seg);
    logic [9:0] act, exp;
    for (int r = first; r <= last; r++) begin
      bus.start     = vecs[r].st;
      bus.out_ready = vecs[r].rdy;
      @(negedge clk);
      act = {bus.busy, bus.done, bus.rd_en, bus.vmm_ce, bus.out_valid, bus.out_last,
             vecs[r].re ? bus.rd_addr : 2'd0, vecs[r].vl ? bus.out_idx : 2'd0};
      exp = {vecs[r].bsy, vecs[r].dn, vecs[r].re, vecs[r].ce, vecs[r].vl, vecs[r].ls,
             vecs[r].re ? 2'(vecs[r].ra) : 2'd0, vecs[r].vl ? 2'(vecs[r].ix) : 2'd0};
      chk($sformatf("seg%0d row%0d ctl", seg, r - first), 64'(act), 64'(exp));
      if (vecs[r].vl) chk_y($sformatf("seg%0d row%0d", seg, r - first), vecs[r].ix);
      step();
    end
    bus.start = 1'b0;
  endtask

  localparam int NOM0 = 0, BP0 = 12, BS0 = 27, VEND = 41;

  initial begin
    passed = 0;
    total  = 0;
    // Nominal job, out_ready held high.
    vecs.push_back(v(1,1, 0,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,1, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,2, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,3, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,1,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,2,0));
    vecs.push_back(v(0,1, 1,0,0,0, 0,1,3,1));
    vecs.push_back(v(0,1, 0,1,0,0, 0,0,0,0));
    // out_ready low in cycles 7..9.
    vecs.push_back(v(1,1, 0,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,1, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,2, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,3, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,0, 1,0,0,0, 0,1,0,0));
    vecs.push_back(v(0,0, 1,0,0,0, 0,1,0,0));
    vecs.push_back(v(0,0, 1,0,0,0, 0,1,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,1,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,2,0));
    vecs.push_back(v(0,1, 1,0,0,0, 0,1,3,1));
    vecs.push_back(v(0,1, 0,1,0,0, 0,0,0,0));
    // start pulses in cycles 2 and 8 are ignored; no second job follows.
    vecs.push_back(v(1,1, 0,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,0, 1,0,0,0));
    vecs.push_back(v(1,1, 1,0,1,1, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,2, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,1,3, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,0,0,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,0,0));
    vecs.push_back(v(1,1, 1,0,0,0, 1,1,1,0));
    vecs.push_back(v(0,1, 1,0,0,0, 1,1,2,0));
    vecs.push_back(v(0,1, 1,0,0,0, 0,1,3,1));
    vecs.push_back(v(0,1, 0,1,0,0, 0,0,0,0));
    vecs.push_back(v(0,1, 0,0,0,0, 0,0,0,0));
    vecs.push_back(v(0,1, 0,0,0,0, 0,0,0,0));

    rst = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    load(32'h1234_0000);
    repeat (3) step();
    @(negedge clk);
    chk("reset ctl", 64'({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.vmm_ce,
                          bus.out_valid, bus.out_idx, bus.out_last}), 64'd0);
    chk("reset y", {bus.out_y_r, bus.out_y_i}, 64'd0);
    step();
    rst = 1'b1;
    step();

    run_seg(NOM0, BP0 - 1, 0);
    load(32'h8000_0010);
    run_seg(BP0, BS0 - 1, 1);
    load(32'h7FFF_FFF0);
    run_seg(BS0, VEND - 1, 2);

    // Reset while RUN at t=3, then a fresh job must complete correctly.
    load(32'hDEAD_0000);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("pre-reset addr", 64'({bus.rd_en, bus.rd_addr}), 64'({1'b1, 2'd3}));
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("midjob reset ctl", 64'({bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.vmm_ce,
                                 bus.out_valid, bus.out_idx, bus.out_last}), 64'd0);
    chk("midjob reset y", {bus.out_y_r, bus.out_y_i}, 64'd0);
    step();
    rst = 1'b1;
    step();
    load(32'h0BAD_F00D);
    run_seg(NOM0, BP0 - 1, 3);

    // Five-cycle stall in DRAIN with idx 3 pending.
    load(32'h0000_FFF8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("drain stall c%0d", c),
          64'({bus.vmm_ce, bus.rd_en, bus.busy, bus.out_valid, bus.out_idx, bus.out_last, bus.done}),
          64'({1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0}));
      step();
    end
    chk_y("drain stall", 3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("drain handshake", 64'({bus.busy, bus.out_valid, bus.done}), 64'({1'b1, 1'b1, 1'b0}));
    step();
    @(negedge clk);
    chk("drain done", 64'({bus.busy, bus.out_valid, bus.done}), 64'({1'b0, 1'b0, 1'b1}));
    step();
    @(negedge clk);
    chk("done pulse width", 64'(bus.done), 64'd0);
    step();

    // Back-to-back: second start issued in the first job's done cycle.
    load(32'h5555_0000);
    run_seg(NOM0, NOM0 + 10, 4);
    bus.start = 1'b1;
    @(negedge clk);
    chk("b2b done cycle", 64'({bus.busy, bus.done, bus.rd_en}), 64'({1'b0, 1'b1, 1'b0}));
    load(32'hAAAA_0003);
    step();
    bus.start = 1'b0;
    run_seg(NOM0 + 1, BP0 - 1, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
